// File: rtl/down_counter_timer_pkg.sv
// Shared types and defaults for the loadable down-counter timer.
package down_counter_timer_pkg;

  localparam int DEF_WIDTH = 5;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tmr_state_e;

endpackage

// File: rtl/down_counter_timer_if.sv
// Control/status bundle of the down-counter timer. The master side drives
// load/start/stop/enab and the reload value; the slave (the timer) returns
// the registered count and status flags.
interface down_counter_timer_if
  import down_counter_timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             load;
  logic [WIDTH-1:0] cnt_in;
  logic             start;
  logic             stop;
  logic             enab;
  logic [WIDTH-1:0] cnt_out;
  logic             busy;
  logic             done;
  logic             expired;

  modport master (
    output load, cnt_in, start, stop, enab,
    input  cnt_out, busy, done, expired
  );

  modport slave (
    input  load, cnt_in, start, stop, enab,
    output cnt_out, busy, done, expired
  );

endinterface

// File: rtl/down_counter_timer.sv
// Loadable down-counter with start/stop control. Counts a loaded value down
// to zero on enab ticks, then pulses done and sets the sticky expired flag.
// Optional macro AUTO_RELOAD_EN: on reaching the terminal count the counter
// reloads from the last loaded value and keeps running (periodic mode).
module down_counter_timer
  import down_counter_timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  down_counter_timer_if.slave bus
);

  tmr_state_e       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;
  logic             expired_q, expired_d;
  logic             terminal;

  // Last tick of a run: the count is 1 and an enabled tick arrives.
  assign terminal = (state_q == RUN) && bus.enab && (cnt_q == WIDTH'(1));

  // Next-state decode; priority load > stop > start > enab.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    reload_d  = reload_q;
    done_d    = 1'b0;
    expired_d = expired_q;
    if (bus.load) begin
      cnt_d     = bus.cnt_in;
      reload_d  = bus.cnt_in;
      state_d   = IDLE;
      expired_d = 1'b0;
    end else if (bus.stop) begin
      // Abort holds the count; in IDLE this is a no-op but still masks start.
      state_d = IDLE;
    end else if (bus.start && (state_q == IDLE)) begin
      if (cnt_q == '0) begin
        // Zero-length timer: complete immediately without entering RUN.
        done_d    = 1'b1;
        expired_d = 1'b1;
      end else begin
        state_d   = RUN;
        expired_d = 1'b0;
      end
    end else if (terminal) begin
      done_d    = 1'b1;
      expired_d = 1'b1;
`ifdef AUTO_RELOAD_EN
      if (reload_q != '0) begin
        cnt_d = reload_q;
      end else begin
        cnt_d   = '0;
        state_d = IDLE;
      end
`else
      cnt_d   = '0;
      state_d = IDLE;
`endif
    end else if ((state_q == RUN) && bus.enab && (cnt_q > WIDTH'(1))) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  // State and output registers; reset drops any pending done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      reload_q  <= '0;
      done_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      reload_q  <= reload_d;
      done_q    <= done_d;
      expired_q <= expired_d;
    end
  end

  assign bus.cnt_out = cnt_q;
  assign bus.busy    = (state_q == RUN);
  assign bus.done    = done_q;
  assign bus.expired = expired_q;

endmodule
